lm80c_video_out: RTL and testbench
==================================

// Module: lm80c_video_out
// PURPOSE
//  Pixel-rate video back end between the LM80C TMS9918A VDP core and the MiSTer video outputs, clocked on clk_vdp.
//  - Generates the half-rate pixel strobe ce_pix.
//  - Maps 4-bit VDP colour indices to 6-bit RGB.
//  - Forces black in blanking and aligns syncs/blanks with the colour pipeline.
//  - Measures lines per frame and flags NTSC/PAL and a mismatch with the OSD TV mode.
// PARAMETERS
//  HS_IN_ACTIVE_LOW   1    vdp_hs is active-low; it is inverted internally to active-high.
//  VS_IN_ACTIVE_LOW   1    vdp_vs is active-low; it is inverted internally to active-high.
//  PAL_LINE_THRESHOLD 300  A frame with lines_per_frame >= this value is PAL.
// PORTS
//  clk_vdp          in   1   VDP clock (10.738636 MHz); all logic on its rising edge.
//  reset            in   1   Asynchronous, active-high.
//  vdp_color        in   4   TMS9918 colour index for the current pixel.
//  vdp_hs           in   1   VDP hsync; polarity set by HS_IN_ACTIVE_LOW.
//  vdp_vs           in   1   VDP vsync; polarity set by VS_IN_ACTIVE_LOW.
//  vdp_hblank       in   1   Horizontal blank, active-high.
//  vdp_vblank       in   1   Vertical blank, active-high.
//  tv_pal           in   1   OSD TV mode: 0 = NTSC, 1 = PAL.
//  scanlines        in   1   Scanline darkening request. Used only when the macro is defined.
//  ce_pix           out  1   Pixel strobe: 1 clk high out of every 2.
//  r, g, b          out  6   Pixel colour (three ports, each 6 bits).
//  hs, vs           out  1   Active-high syncs, pipeline-aligned with r/g/b.
//  hblank, vblank   out  1   Pipeline-aligned blanks.
//  lines_per_frame  out  10  HS count of the last complete frame.
//  pal_detected     out  1   lines_per_frame >= PAL_LINE_THRESHOLD.
//  mode_mismatch    out  1   frame_valid & (pal_detected != tv_pal).
// BEHAVIOUR
//  Reset values: every output is 0, including ce_pix, lines_per_frame, pal_detected and mode_mismatch.
//    The internal frame_valid flag and line counter are also 0.
//  Strobe: ce_div toggles every clk.
//    ce_pix <= (ce_div == 0), so the first ce_pix pulse is on the 2nd clk after reset release.
//  Pipeline: two stages, both advancing only in cycles where ce_pix == 1; outputs hold otherwise.
//    S1 registers vdp_color, the normalised syncs and both blanks.
//    S2 performs the palette lookup and blanking and drives every output.
//    Latency is exactly 2 ce_pix strobes, identical for colour, syncs and blanks.
//  Palette: top 6 bits of the standard TMS9918 8-bit RGB. Index: R,G,B in decimal.
//    0:0,0,0    1:0,0,0     2:8,50,16   3:23,55,30
//    4:21,21,59 5:31,29,63  6:53,20,19  7:16,58,61
//    8:63,21,21 9:63,30,30  A:53,48,21  B:57,51,32
//    C:8,44,14  D:50,22,46  E:51,51,51  F:63,63,63
//    Index 0 (transparent) renders as black.
//  Blanking: if S1 hblank or S1 vblank, then r/g/b = 0. Syncs and blanks pass through unchanged.
//  Line counter: 10-bit.
//    Increments on each rising edge of the S1 active-high hs (edge detected on ce_pix cycles).
//    Saturates at 1023; it does not wrap.
//  Frame boundary: on each S1 vs rising edge:
//    lines_per_frame <= counter; counter <= 0.
//    frame_valid is set on the second vs edge (first complete frame) and never clears except by reset.
//  Simultaneous hs and vs rising edges: vs wins.
//    The HS edge is not counted in the old frame; the counter restarts at 0.
//  pal_detected and mode_mismatch are registered.
//    They update in the clk after lines_per_frame updates, and hold between frames.
//  Reset mid-frame: everything clears.
//    Measurement restarts; mode_mismatch stays 0 until frame_valid is set again.
//  Inputs are synchronous to clk_vdp; no CDC is performed here.
// CONFIGURATION
//  LM80C_VIDEO_SCANLINES_EN
//    Defined: when scanlines == 1 and line counter bit 0 == 1, each of r/g/b is halved
//      (value >> 1) at S2. This is applied after blanking; latency is unchanged.
//    Undefined: the scanlines input is ignored and no darkening logic is generated.
// TESTING
//  1. Reset release, inputs idle -> ce_pix pattern 0,1,0,1,... starting on clk 2; all outputs 0.
//  2. vdp_color = 2, no blank, held 3 strobes -> r,g,b = 8,50,16 on the 2nd ce_pix. Repeat for F -> 63,63,63.
//  3. vdp_color = F with vdp_hblank = 1 -> r,g,b = 0,0,0. Output hblank = 1 with the same 2-strobe latency.
//  4. Frames of 262 HS pulses and tv_pal = 0 -> after the 2nd frame: lines_per_frame = 262, pal_detected = 0, mode_mismatch = 0.
//     Then 313-line frames -> pal_detected = 1 and mode_mismatch = 1.
//  5. 1100 HS pulses with no VS, then VS -> lines_per_frame = 1023 (saturated). HS and VS on the same strobe -> that HS is not counted.
//  6. With LM80C_VIDEO_SCANLINES_EN, scanlines = 1, colour F on an odd line -> r,g,b = 31,31,31; on an even line -> 63,63,63.
//     Without the macro -> 63,63,63 on every line.

Source files
------------

// File: rtl/lm80c_video_out.sv
`default_nettype none
// ============================================================================
// Module      : lm80c_video_out
// Description : Pixel-rate video back end between the TMS9918A VDP core and
//               the video outputs, clocked on clk_vdp.
//               - half-rate pixel strobe (ce_pix)
//               - 4-bit colour index to 6-bit RGB palette, black in blanking
//               - syncs/blanks delayed to line up with the colour pipeline
//               - lines-per-frame measurement, NTSC/PAL detection and a
//                 mismatch flag against the OSD TV mode
// Ports       : clk_vdp, reset (async, active-high)
//               vdp_color[3:0], vdp_hs, vdp_vs, vdp_hblank, vdp_vblank,
//               tv_pal, scanlines                                  (inputs)
//               ce_pix, r/g/b[5:0], hs, vs, hblank, vblank,
//               lines_per_frame[9:0], pal_detected, mode_mismatch (outputs)
// Config      : LM80C_VIDEO_SCANLINES_EN - when defined, scanlines = 1 halves
//               r/g/b on odd lines; when undefined the input is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module lm80c_video_out #(
  parameter bit HS_IN_ACTIVE_LOW   = 1'b1,
  parameter bit VS_IN_ACTIVE_LOW   = 1'b1,
  parameter int PAL_LINE_THRESHOLD = 300
) (
  input  logic       clk_vdp,
  input  logic       reset,
  input  logic [3:0] vdp_color,
  input  logic       vdp_hs,
  input  logic       vdp_vs,
  input  logic       vdp_hblank,
  input  logic       vdp_vblank,
  input  logic       tv_pal,
  input  logic       scanlines,
  output logic       ce_pix,
  output logic [5:0] r,
  output logic [5:0] g,
  output logic [5:0] b,
  output logic       hs,
  output logic       vs,
  output logic       hblank,
  output logic       vblank,
  output logic [9:0] lines_per_frame,
  output logic       pal_detected,
  output logic       mode_mismatch
);

  localparam logic [9:0] C_PAL_THRESHOLD = 10'(PAL_LINE_THRESHOLD);
  localparam logic [9:0] C_LINE_MAX      = 10'h3FF;

  // Top 6 bits of the TMS9918 8-bit RGB palette, packed {R,G,B}.
  function automatic logic [17:0] palette(input logic [3:0] idx);
    case (idx)
      4'h0:    palette = {6'd0,  6'd0,  6'd0 };  // transparent -> black
      4'h1:    palette = {6'd0,  6'd0,  6'd0 };
      4'h2:    palette = {6'd8,  6'd50, 6'd16};
      4'h3:    palette = {6'd23, 6'd55, 6'd30};
      4'h4:    palette = {6'd21, 6'd21, 6'd59};
      4'h5:    palette = {6'd31, 6'd29, 6'd63};
      4'h6:    palette = {6'd53, 6'd20, 6'd19};
      4'h7:    palette = {6'd16, 6'd58, 6'd61};
      4'h8:    palette = {6'd63, 6'd21, 6'd21};
      4'h9:    palette = {6'd63, 6'd30, 6'd30};
      4'hA:    palette = {6'd53, 6'd48, 6'd21};
      4'hB:    palette = {6'd57, 6'd51, 6'd32};
      4'hC:    palette = {6'd8,  6'd44, 6'd14};
      4'hD:    palette = {6'd50, 6'd22, 6'd46};
      4'hE:    palette = {6'd51, 6'd51, 6'd51};
      default: palette = {6'd63, 6'd63, 6'd63};
    endcase
  endfunction

  logic        r_ce_div;
  logic        r_ce_pix;
  logic [3:0]  r_s1_color;
  logic        r_s1_hs, r_s1_vs, r_s1_hblank, r_s1_vblank;
  logic [17:0] r_rgb;
  logic        r_hs, r_vs, r_hblank, r_vblank;
  logic [9:0]  r_line_cnt;
  logic [9:0]  r_lines_per_frame;
  logic        r_vs_seen;
  logic        r_frame_valid;
  logic        r_pal_detected;
  logic        r_mode_mismatch;

  logic        w_hs_in, w_vs_in;
  logic        w_hs_rise, w_vs_rise;
  logic [17:0] w_rgb_blanked;
  logic [17:0] w_rgb_out;
  logic        w_pal_now;

  // Normalise the VDP syncs to active-high.
  assign w_hs_in = vdp_hs ^ HS_IN_ACTIVE_LOW;
  assign w_vs_in = vdp_vs ^ VS_IN_ACTIVE_LOW;

  // The S2 sync registers hold the S1 value from the previous strobe, so they
  // double as the edge-detect history: a rise is seen in the same strobe in
  // which the S1 sync value is passed on to the outputs.
  assign w_hs_rise = r_ce_pix & r_s1_hs & ~r_hs;
  assign w_vs_rise = r_ce_pix & r_s1_vs & ~r_vs;

  assign w_rgb_blanked = (r_s1_hblank | r_s1_vblank) ? 18'd0 : palette(r_s1_color);

`ifdef LM80C_VIDEO_SCANLINES_EN
  // Darken odd lines by halving each channel, after blanking.
  assign w_rgb_out = (scanlines & r_line_cnt[0])
                   ? {1'b0, w_rgb_blanked[17:13], 1'b0, w_rgb_blanked[11:7],
                      1'b0, w_rgb_blanked[5:1]}
                   : w_rgb_blanked;
`else
  logic w_unused_scanlines;
  assign w_unused_scanlines = scanlines;
  assign w_rgb_out          = w_rgb_blanked;
`endif

  assign w_pal_now = (r_lines_per_frame >= C_PAL_THRESHOLD);

  // Pixel strobe: high on the clock after ce_div was 0.
  always_ff @(posedge clk_vdp or posedge reset) begin
    if (reset) begin
      r_ce_div <= 1'b0;
      r_ce_pix <= 1'b0;
    end else begin
      r_ce_div <= ~r_ce_div;
      r_ce_pix <= (r_ce_div == 1'b0);
    end
  end

  // Two-stage colour/sync pipeline, advancing only on strobe cycles.
  always_ff @(posedge clk_vdp or posedge reset) begin
    if (reset) begin
      r_s1_color  <= 4'd0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_hblank <= 1'b0;
      r_s1_vblank <= 1'b0;
      r_rgb       <= 18'd0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_hblank    <= 1'b0;
      r_vblank    <= 1'b0;
    end else if (r_ce_pix) begin
      r_s1_color  <= vdp_color;
      r_s1_hs     <= w_hs_in;
      r_s1_vs     <= w_vs_in;
      r_s1_hblank <= vdp_hblank;
      r_s1_vblank <= vdp_vblank;
      r_rgb       <= w_rgb_out;
      r_hs        <= r_s1_hs;
      r_vs        <= r_s1_vs;
      r_hblank    <= r_s1_hblank;
      r_vblank    <= r_s1_vblank;
    end
  end

  // Line/frame measurement. A VS edge takes priority over a coincident HS
  // edge, so that HS is counted in neither frame.
  always_ff @(posedge clk_vdp or posedge reset) begin
    if (reset) begin
      r_line_cnt        <= 10'd0;
      r_lines_per_frame <= 10'd0;
      r_vs_seen         <= 1'b0;
      r_frame_valid     <= 1'b0;
      r_pal_detected    <= 1'b0;
      r_mode_mismatch   <= 1'b0;
    end else begin
      if (w_vs_rise) begin
        r_lines_per_frame <= r_line_cnt;
        r_line_cnt        <= 10'd0;
        r_vs_seen         <= 1'b1;
        // The first VS edge only opens a frame; the second closes a full one.
        if (r_vs_seen) begin
          r_frame_valid <= 1'b1;
        end
      end else if (w_hs_rise && (r_line_cnt != C_LINE_MAX)) begin
        r_line_cnt <= r_line_cnt + 10'd1;
      end
      r_pal_detected  <= w_pal_now;
      r_mode_mismatch <= r_frame_valid & (w_pal_now != tv_pal);
    end
  end

  assign ce_pix          = r_ce_pix;
  assign r               = r_rgb[17:12];
  assign g               = r_rgb[11:6];
  assign b               = r_rgb[5:0];
  assign hs              = r_hs;
  assign vs              = r_vs;
  assign hblank          = r_hblank;
  assign vblank          = r_vblank;
  assign lines_per_frame = r_lines_per_frame;
  assign pal_detected    = r_pal_detected;
  assign mode_mismatch   = r_mode_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_lm80c_video_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_lm80c_video_out
// Description : Directed self-checking bench for lm80c_video_out: strobe,
//               palette, blanking, sync alignment, line counting, PAL
//               detection, saturation, reset and optional scanlines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lm80c_video_out;

  logic       clk_vdp = 1'b0;
  logic       reset;
  logic [3:0] vdp_color;
  logic       vdp_hs, vdp_vs, vdp_hblank, vdp_vblank;
  logic       tv_pal, scanlines;
  logic       ce_pix;
  logic [5:0] r, g, b;
  logic       hs, vs, hblank, vblank;
  logic [9:0] lines_per_frame;
  logic       pal_detected, mode_mismatch;

  int checks = 0;
  int errors = 0;

  lm80c_video_out dut (
    .clk_vdp        (clk_vdp),
    .reset          (reset),
    .vdp_color      (vdp_color),
    .vdp_hs         (vdp_hs),
    .vdp_vs         (vdp_vs),
    .vdp_hblank     (vdp_hblank),
    .vdp_vblank     (vdp_vblank),
    .tv_pal         (tv_pal),
    .scanlines      (scanlines),
    .ce_pix         (ce_pix),
    .r              (r),
    .g              (g),
    .b              (b),
    .hs             (hs),
    .vs             (vs),
    .hblank         (hblank),
    .vblank         (vblank),
    .lines_per_frame(lines_per_frame),
    .pal_detected   (pal_detected),
    .mode_mismatch  (mode_mismatch)
  );

  always #5 clk_vdp = ~clk_vdp;

  task automatic step();
    @(posedge clk_vdp);
    #1;
  endtask

  // Advance until one strobe edge (ce_pix high before the edge) has passed.
  task automatic strobe();
    logic was;
    int   n;
    n = 0;
    do begin
      was = ce_pix;
      step();
      n++;
    end while (!was && n < 4);
    if (!was) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: ce_pix stayed %0b for %0d clocks, required a 1", ce_pix, n);
    end
  endtask

  task automatic put_pixel(input logic [3:0] c, input logic hs_a, input logic vs_a,
                           input logic hb, input logic vb);
    vdp_color  = c;
    vdp_hs     = ~hs_a;
    vdp_vs     = ~vs_a;
    vdp_hblank = hb;
    vdp_vblank = vb;
    strobe();
  endtask

  task automatic send_lines(input int n);
    for (int i = 0; i < n; i++) begin
      put_pixel(4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      put_pixel(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_vs();
    put_pixel(4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    put_pixel(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
  endtask

  task automatic set_idle();
    vdp_color = 4'h0; vdp_hs = 1'b1; vdp_vs = 1'b1;
    vdp_hblank = 1'b0; vdp_vblank = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] all_out;
    reset = 1'b1;
    set_idle();
    tv_pal = 1'b0;
    scanlines = 1'b0;
    step();
    step();
    all_out = {r, g, b, hs, vs, hblank, vblank, lines_per_frame, pal_detected, mode_mismatch};
    checks++;
    if ({ce_pix, all_out} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {ce_pix, all_out});
    end
    reset = 1'b0;
    checks++;
    if (ce_pix !== 1'b0) begin
      errors++;
      $display("FAIL ce_pix_clk1: got %b, required 0", ce_pix);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ce_pix !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL ce_pix_pattern[%0d]: got %b, required %b", i, ce_pix, ((i % 2) == 0));
      end
    end
    all_out = {r, g, b, hs, vs, hblank, vblank, lines_per_frame, pal_detected, mode_mismatch};
    checks++;
    if (all_out !== 36'd0) begin
      errors++;
      $display("FAIL idle_outputs: got %h, required 0", all_out);
    end
  endtask

  task automatic test_colour();
    logic [3:0]  idx [4];
    logic [17:0] rgb [4];
    logic [17:0] prev;
    idx[0] = 4'h2; rgb[0] = {6'd8,  6'd50, 6'd16};
    idx[1] = 4'hF; rgb[1] = {6'd63, 6'd63, 6'd63};
    idx[2] = 4'h8; rgb[2] = {6'd63, 6'd21, 6'd21};
    idx[3] = 4'h0; rgb[3] = 18'd0;
    prev = 18'd0;
    for (int k = 0; k < 4; k++) begin
      put_pixel(idx[k], 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({r, g, b} !== prev) begin
        errors++;
        $display("FAIL colour_latency[%h]: got %0d,%0d,%0d, required %0d,%0d,%0d",
                 idx[k], r, g, b, prev[17:12], prev[11:6], prev[5:0]);
      end
      put_pixel(idx[k], 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({r, g, b} !== rgb[k]) begin
        errors++;
        $display("FAIL colour[%h]: got %0d,%0d,%0d, required %0d,%0d,%0d",
                 idx[k], r, g, b, rgb[k][17:12], rgb[k][11:6], rgb[k][5:0]);
      end
      prev = rgb[k];
    end
  endtask

  task automatic test_blank();
    // Each entry: pixel driven, then expected {rgb, hblank, vblank} after its strobe.
    logic        hb_in [5];
    logic        vb_in [5];
    logic [19:0] exp_o [5];
    hb_in[0] = 1'b1; vb_in[0] = 1'b0; exp_o[0] = {18'd0, 1'b0, 1'b0};
    hb_in[1] = 1'b1; vb_in[1] = 1'b0; exp_o[1] = {18'd0, 1'b1, 1'b0};
    hb_in[2] = 1'b0; vb_in[2] = 1'b1; exp_o[2] = {18'd0, 1'b1, 1'b0};
    hb_in[3] = 1'b0; vb_in[3] = 1'b0; exp_o[3] = {18'd0, 1'b0, 1'b1};
    hb_in[4] = 1'b0; vb_in[4] = 1'b0; exp_o[4] = {6'd63, 6'd63, 6'd63, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      put_pixel(4'hF, 1'b0, 1'b0, hb_in[k], vb_in[k]);
      checks++;
      if ({r, g, b, hblank, vblank} !== exp_o[k]) begin
        errors++;
        $display("FAIL blank[%0d]: got rgb=%0d,%0d,%0d hb=%b vb=%b, required rgb=%0d,%0d,%0d hb=%b vb=%b",
                 k, r, g, b, hblank, vblank, exp_o[k][19:14], exp_o[k][13:8], exp_o[k][7:2],
                 exp_o[k][1], exp_o[k][0]);
      end
    end
  endtask

  task automatic test_sync_align();
    logic       hs_in [5];
    logic       vs_in [5];
    logic [1:0] exp_o [5];
    hs_in[0] = 1'b1; vs_in[0] = 1'b0; exp_o[0] = 2'b00;
    hs_in[1] = 1'b0; vs_in[1] = 1'b0; exp_o[1] = 2'b10;
    hs_in[2] = 1'b0; vs_in[2] = 1'b1; exp_o[2] = 2'b00;
    hs_in[3] = 1'b0; vs_in[3] = 1'b0; exp_o[3] = 2'b01;
    hs_in[4] = 1'b0; vs_in[4] = 1'b0; exp_o[4] = 2'b00;
    for (int k = 0; k < 5; k++) begin
      put_pixel(4'h0, hs_in[k], vs_in[k], 1'b0, 1'b0);
      checks++;
      if ({hs, vs} !== exp_o[k]) begin
        errors++;
        $display("FAIL sync_align[%0d]: got hs=%b vs=%b, required hs=%b vs=%b",
                 k, hs, vs, exp_o[k][1], exp_o[k][0]);
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [9:0] lines,
                             input logic pal, input logic mism);
    checks++;
    if ({lines_per_frame, pal_detected, mode_mismatch} !== {lines, pal, mism}) begin
      errors++;
      $display("FAIL %s: got lines=%0d pal=%b mismatch=%b, required lines=%0d pal=%b mismatch=%b",
               name, lines_per_frame, pal_detected, mode_mismatch, lines, pal, mism);
    end
  endtask

  task automatic test_frames();
    do_reset();
    tv_pal = 1'b0;
    send_vs();
    check_frame("first_vs", 10'd0, 1'b0, 1'b0);
    tv_pal = 1'b1;
    step();
    step();
    check_frame("no_valid_frame_yet", 10'd0, 1'b0, 1'b0);
    tv_pal = 1'b0;
    send_lines(262);
    send_vs();
    check_frame("ntsc_262", 10'd262, 1'b0, 1'b0);
    send_lines(313);
    send_vs();
    check_frame("pal_313_mismatch", 10'd313, 1'b1, 1'b1);
    tv_pal = 1'b1;
    step();
    step();
    check_frame("pal_313_osd_pal", 10'd313, 1'b1, 1'b0);
    tv_pal = 1'b0;
    send_lines(300);
    send_vs();
    check_frame("threshold_300", 10'd300, 1'b1, 1'b1);
    send_lines(299);
    send_vs();
    check_frame("threshold_299", 10'd299, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    send_lines(1100);
    send_vs();
    check_frame("saturate_1023", 10'd1023, 1'b1, 1'b1);
    send_lines(5);
    put_pixel(4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    put_pixel(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_frame("hs_vs_same_old", 10'd5, 1'b0, 1'b0);
    send_lines(3);
    send_vs();
    check_frame("hs_vs_same_new", 10'd3, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    logic [35:0] all_out;
    send_lines(50);
    reset = 1'b1;
    step();
    all_out = {r, g, b, hs, vs, hblank, vblank, lines_per_frame, pal_detected, mode_mismatch};
    checks++;
    if (all_out !== 36'd0) begin
      errors++;
      $display("FAIL reset_midframe_outputs: got %h, required 0", all_out);
    end
    reset = 1'b0;
    tv_pal = 1'b0;
    send_lines(310);
    send_vs();
    check_frame("after_reset_partial", 10'd310, 1'b1, 1'b0);
    send_lines(310);
    send_vs();
    check_frame("after_reset_full", 10'd310, 1'b1, 1'b1);
  endtask

  task automatic test_scanlines();
    logic [17:0] exp_odd;
    logic [17:0] full;
    full = {6'd63, 6'd63, 6'd63};
`ifdef LM80C_VIDEO_SCANLINES_EN
    exp_odd = {6'd31, 6'd31, 6'd31};
`else
    exp_odd = full;
`endif
    do_reset();
    scanlines = 1'b1;
    send_lines(1);
    put_pixel(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    put_pixel(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({r, g, b} !== exp_odd) begin
      errors++;
      $display("FAIL scanline_odd: got %0d,%0d,%0d, required %0d,%0d,%0d",
               r, g, b, exp_odd[17:12], exp_odd[11:6], exp_odd[5:0]);
    end
    send_lines(1);
    put_pixel(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    put_pixel(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({r, g, b} !== full) begin
      errors++;
      $display("FAIL scanline_even: got %0d,%0d,%0d, required 63,63,63", r, g, b);
    end
    scanlines = 1'b0;
    send_lines(1);
    put_pixel(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    put_pixel(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({r, g, b} !== full) begin
      errors++;
      $display("FAIL scanline_off_odd: got %0d,%0d,%0d, required 63,63,63", r, g, b);
    end
  endtask

  initial begin
    test_reset();
    test_colour();
    test_blank();
    test_sync_align();
    test_frames();
    test_saturation();
    test_reset_midframe();
    test_scanlines();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
